wb_scheduler: RTL
=================

Name: wb_scheduler

Overview:
- Arbitrates register-file writeback between several datapath requesters: the main control FSM, the mult/div unit, the load unit and the shift unit.
- Each request carries a writeback-source select code and a destination register number.
- The block grants one request per cycle and drives the 3-bit MemToReg select, the RegWrite strobe and the write-register address.
- Sits between the requesters and the MemToReg writeback mux / register bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HI_SEL, 3'b010, MemToReg code for HI.
- LO_SEL, 3'b011, MemToReg code for LO.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester write request.
- req_sel  in  3*NREQ  MemToReg code for requester i, bits [3i+2:3i].
- req_rd  in  5*NREQ  destination register for requester i, bits [5i+4:5i].
- hilo_busy  in  1  mult/div in progress; HI/LO contents not yet valid.
- req_ack  out  NREQ  one-cycle grant/accept pulse, at most one bit set.
- mem_to_reg  out  3  select to the writeback mux.
- reg_write  out  1  register-bank write enable.
- write_reg  out  5  register-bank write address.
- busy  out  1  high in WRITE state.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, req_ack=0, mem_to_reg=3'b000, reg_write=0, write_reg=0, busy=0.
  - RR pointer=0, so requester 0 has highest priority.
  - Reset mid-WRITE aborts the write immediately; reg_write drops asynchronously.
- Eligibility: requester i is eligible iff req_valid[i]=1 and NOT (hilo_busy=1 and req_sel_i is HI_SEL or LO_SEL).
- Arbitration: round-robin.
  - Search starts at index ptr and wraps modulo NREQ; the first eligible index wins.
  - On a grant, ptr <= winner+1, wrapping to 0 after NREQ-1.
  - With no grant, ptr is unchanged.
- FSM, evaluated every cycle in both states:
  - IDLE, no eligible request: stay IDLE, req_ack=0.
  - IDLE or WRITE, an eligible request exists (combinational decision):
    - req_ack[winner]=1 this cycle.
    - At the edge, register mem_to_reg<=sel and write_reg<=rd; next state WRITE.
  - WRITE, no eligible request: next state IDLE.
  - reg_write=1 for exactly the cycles in WRITE, with mem_to_reg and write_reg held from the grant edge.
  - Exception: if the latched rd==0, reg_write=0 in that WRITE cycle ($zero never written). The ack is still given and the state is still WRITE.
- Latency and throughput:
  - Grant at cycle N; write occurs in cycle N+1.
  - Back-to-back grants give one write per cycle.
- Outputs are registered except req_ack, which is combinational from the inputs and current ptr.
- In IDLE, mem_to_reg and write_reg hold their last values; reg_write=0.
- Requester rules:
  - Hold req_sel and req_rd stable while req_valid=1, until the ack cycle.
  - Deassert or reissue after the ack.
  - Dropping req_valid before ack is legal and causes no write.
  - A requester still valid in the cycle after its ack is treated as a new request.
- hilo_busy rising while a HI/LO request is already latched in WRITE has no effect; that write completes.
- Simultaneous eligibility of all requesters: serviced in RR order, each exactly once per NREQ grants.

Test Plan:
- Reset: drive reset=0 mid-WRITE -> reg_write=0, mem_to_reg=000, write_reg=0, busy=0 without waiting for a clock edge.
- Single request: req 2 valid, sel=101, rd=8 in cycle 0 -> req_ack=0100 in cycle 0; cycle 1 reg_write=1, mem_to_reg=101, write_reg=8; cycle 2 IDLE, reg_write=0.
- Round-robin: all 4 valid continuously from reset -> acks 0,1,2,3,0 on consecutive cycles; reg_write high continuously from cycle 1.
- HI/LO blocking: req 0 sel=010, req 1 sel=000, hilo_busy=1 -> req 1 granted first, req 0 waits; after hilo_busy drops, req 0 acked the next cycle with mem_to_reg=010.
- $zero squash: req 3 sel=000, rd=0 -> req_ack[3] pulses, busy=1 next cycle, reg_write stays 0.
- Withdraw: req 1 valid for one cycle while req 0 is being granted, then drops -> no ack to 1 and no write to its rd.

Source files
------------

// File: rtl/wb_scheduler.sv
// Purpose: round-robin arbiter granting one register-file writeback per cycle.
// Latency: req_ack is combinational in the grant cycle N; the register write happens in cycle N+1.
// Backpressure: a requester holds req_valid/sel/rd until acked; HI/LO requests stall while hilo_busy.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid[NREQ], req_sel[3*NREQ], req_rd[5*NREQ], hilo_busy   - requests in
//   req_ack[NREQ]                                                 - one-hot grant pulse
//   mem_to_reg[3], reg_write, write_reg[5], busy                   - registered writeback controls
module wb_scheduler #(
  parameter int          NREQ   = 4,
  parameter logic [2:0]  HI_SEL = 3'b010,
  parameter logic [2:0]  LO_SEL = 3'b011
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_sel,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic                 hilo_busy,
  output logic [NREQ-1:0]      req_ack,
  output logic [2:0]           mem_to_reg,
  output logic                 reg_write,
  output logic [4:0]           write_reg,
  output logic                 busy
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;

  logic [NREQ-1:0] elig;
  logic            found;
  logic            grant;
  logic [PW-1:0]   winner;
  logic [NREQ-1:0] ack_vec;
  logic [2:0]      win_sel;
  logic [4:0]      win_rd;

  // HI/LO sources are not readable while a mult/div is still running.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] &&
                !(hilo_busy && ((req_sel[3*i +: 3] == HI_SEL) ||
                                (req_sel[3*i +: 3] == LO_SEL)));
    end
  end

  // Round-robin pick: each requester's priority is its distance from ptr,
  // modulo NREQ; the eligible requester with the smallest distance wins.
  always_comb begin
    int best_d;
    int d;
    found   = 1'b0;
    winner  = '0;
    ack_vec = '0;
    win_sel = 3'b000;
    win_rd  = 5'd0;
    best_d  = NREQ;
    d       = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
      if (elig[i] && (d < best_d)) begin
        best_d  = d;
        found   = 1'b1;
        winner  = PW'(i);
        ack_vec = '0;
        ack_vec[i] = 1'b1;
        win_sel = req_sel[3*i +: 3];
        win_rd  = req_rd[5*i +: 5];
      end
    end
  end

  // No grant may be signalled while the block is held in reset.
  assign grant   = found && reset;
  assign req_ack = grant ? ack_vec : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      mem_to_reg <= 3'b000;
      write_reg  <= 5'd0;
      reg_write  <= 1'b0;
    end else begin
      if (grant) begin
        state      <= WRITE;
        mem_to_reg <= win_sel;
        write_reg  <= win_rd;
        // $zero is architecturally constant: the slot is consumed but not written.
        reg_write  <= (win_rd != 5'd0);
        ptr        <= (winner == PW'(NREQ - 1)) ? '0 : (winner + PW'(1));
      end else begin
        // mem_to_reg / write_reg keep their last values while idle.
        state      <= IDLE;
        reg_write  <= 1'b0;
      end
    end
  end

  assign busy = (state == WRITE);

endmodule
